// File: rtl/memory_bus_pkg.sv
// Shared definitions for the CPU memory responder: region enum, address map
// boundaries and OAM DMA constants.
package memory_bus_pkg;

    typedef enum logic [2:0] {
        CART     = 3'd0,
        VRAM     = 3'd1,
        WRAM     = 3'd2,
        OAM      = 3'd3,
        IO       = 3'd4,
        HRAM     = 3'd5,
        DMA_REG  = 3'd6,
        UNUSABLE = 3'd7
    } mem_region_e;

    typedef enum logic [1:0] {
        DMA_IDLE   = 2'd0,
        DMA_SETUP  = 2'd1,
        DMA_ACTIVE = 2'd2
    } dma_state_e;

    localparam logic [15:0] CART_LO_END  = 16'h7FFF;
    localparam logic [15:0] VRAM_END     = 16'h9FFF;
    localparam logic [15:0] CART_HI_END  = 16'hBFFF;
    localparam logic [15:0] WRAM_END     = 16'hDFFF;
    localparam logic [15:0] ECHO_START   = 16'hE000;
    localparam logic [15:0] ECHO_END     = 16'hFDFF;
    localparam logic [15:0] OAM_START    = 16'hFE00;
    localparam logic [15:0] OAM_END      = 16'hFE9F;
    localparam logic [15:0] UNUSABLE_END = 16'hFEFF;
    localparam logic [15:0] IO_END       = 16'hFF7F;
    localparam logic [15:0] IE_ADDR      = 16'hFFFF;
    localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;

    localparam logic [7:0]  ECHO_SRC_MIN    = 8'hE0;
    localparam int          HRAM_DEPTH      = 127;
    localparam int          DMA_LEN_DEFAULT = 160;

    // Echo RAM (E000-FDFF) aliases C000-DDFF: drop address bit 13.
    function automatic logic [15:0] clear_bit13(input logic [15:0] a);
        return {a[15:14], 1'b0, a[12:0]};
    endfunction

endpackage

// File: rtl/memory_bus_hram.sv
// 127x8 single-port synchronous RAM (high RAM), one-cycle read latency.
// Contents are deliberately left unreset.
module hram
    import memory_bus_pkg::*;
(
    input  logic       clk,
    input  logic       sel,
    input  logic       we,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata
);

    logic [7:0] mem_r [0:HRAM_DEPTH-1];
    logic [7:0] rdata_r;

    // Write on selected write cycles, otherwise register the addressed byte.
    always_ff @(posedge clk) begin
        if (sel) begin
            if (we) begin
                mem_r[addr] <= wdata;
            end else begin
                rdata_r <= mem_r[addr];
            end
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/memory_bus.sv
// CPU memory responder: decodes per-M-cycle requests onto a shared one-hot
// target bus, holds HRAM internally and runs the OAM DMA engine at FF46.
module memory_bus
    import memory_bus_pkg::*;
#(
    parameter int DMA_LEN = DMA_LEN_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  t_cycle,
    input  logic        cpu_mem_enable,
    input  logic        cpu_mem_write,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_data_out,
    output logic [7:0]  cpu_data_in,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_wdata,
    output logic        bus_write,
    output logic        sel_cart,
    output logic        sel_vram,
    output logic        sel_wram,
    output logic        sel_oam,
    output logic        sel_io,
    input  logic [7:0]  cart_rdata,
    input  logic [7:0]  vram_rdata,
    input  logic [7:0]  wram_rdata,
    input  logic [7:0]  oam_rdata,
    input  logic [7:0]  io_rdata,
    output logic        dma_active
);

    localparam logic [7:0] DMA_LAST_IDX = 8'(DMA_LEN - 1);

    function automatic mem_region_e decode_addr(input logic [15:0] a);
        mem_region_e r;
        if (a <= CART_LO_END)       r = CART;
        else if (a <= VRAM_END)     r = VRAM;
        else if (a <= CART_HI_END)  r = CART;
        else if (a <= ECHO_END)     r = WRAM;
        else if (a <= OAM_END)      r = OAM;
        else if (a <= UNUSABLE_END) r = UNUSABLE;
        else if (a == DMA_REG_ADDR) r = DMA_REG;
        else if (a <= IO_END)       r = IO;
        else if (a == IE_ADDR)      r = IO;
        else                        r = HRAM;
        return r;
    endfunction

    function automatic logic [7:0] read_mux(input mem_region_e r,
                                            input logic [7:0] cart, vram, wram,
                                            input logic [7:0] oam, io, hr, dreg);
        logic [7:0] d;
        case (r)
            CART:    d = cart;
            VRAM:    d = vram;
            WRAM:    d = wram;
            OAM:     d = oam;
            IO:      d = io;
            HRAM:    d = hr;
            DMA_REG: d = dreg;
            default: d = 8'hFF;
        endcase
        return d;
    endfunction

    dma_state_e  state_r, next_state_s;
    logic [7:0]  idx_r, next_idx_s;
    logic [7:0]  src_r;
    logic        load_src_s, start_s, boundary_s;
    logic        dma_active_r;

    logic [15:0] dma_base_s, dma_src_addr_s;
    mem_region_e dma_src_region_s, dma_region_r;
    mem_region_e cpu_region_s, cpu_eff_region_s, cpu_region_r;
    logic        cpu_rd_r, cpu_wr_r;
    logic [7:0]  cpu_rd_data_s, dma_rd_data_s;

    logic        sel_cart_r, sel_vram_r, sel_wram_r, sel_oam_r, sel_io_r;
    logic        sel_any_s;
    logic [15:0] bus_addr_r;
    logic [7:0]  bus_wdata_r, cpu_data_in_r;
    logic        bus_write_r;

    logic        hram_sel_r, hram_we_r;
    logic [6:0]  hram_addr_r;
    logic [7:0]  hram_wdata_r, hram_rdata_s;

    hram u_hram (
        .clk   (clk),
        .sel   (hram_sel_r),
        .we    (hram_we_r),
        .addr  (hram_addr_r),
        .wdata (hram_wdata_r),
        .rdata (hram_rdata_s)
    );

    // DMA next-state: start on FF46 write at the M-cycle boundary, step per M-cycle.
    always_comb begin
        boundary_s   = (t_cycle == 2'd3);
        start_s      = boundary_s && cpu_mem_enable && cpu_mem_write &&
                       (cpu_addr == DMA_REG_ADDR);
        next_state_s = state_r;
        next_idx_s   = idx_r;
        load_src_s   = 1'b0;
        case (state_r)
            DMA_IDLE: begin
                if (start_s) begin
                    next_state_s = DMA_SETUP;
                    load_src_s   = 1'b1;
                end else begin
                    next_state_s = DMA_IDLE;
                end
            end
            DMA_SETUP: begin
                if (start_s) begin
                    next_state_s = DMA_SETUP;
                    load_src_s   = 1'b1;
                end else if (boundary_s) begin
                    next_state_s = DMA_ACTIVE;
                    next_idx_s   = 8'd0;
                end else begin
                    next_state_s = DMA_SETUP;
                end
            end
            DMA_ACTIVE: begin
                if (boundary_s) begin
                    if (idx_r == DMA_LAST_IDX) begin
                        next_state_s = DMA_IDLE;
                        next_idx_s   = 8'd0;
                    end else begin
                        next_idx_s = idx_r + 8'd1;
                    end
                end else begin
                    next_state_s = DMA_ACTIVE;
                end
            end
            default: begin
                next_state_s = DMA_IDLE;
                next_idx_s   = 8'd0;
            end
        endcase
    end

    // DMA state, index, source page and the registered active flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= DMA_IDLE;
            idx_r        <= 8'd0;
            src_r        <= 8'h00;
            dma_active_r <= 1'b0;
        end else begin
            state_r      <= next_state_s;
            idx_r        <= next_idx_s;
            dma_active_r <= (next_state_s == DMA_ACTIVE);
            if (load_src_s) begin
                src_r <= cpu_data_out;
            end else begin
                src_r <= src_r;
            end
        end
    end

    // Address/region decode for the CPU request and the upcoming DMA source byte.
    always_comb begin
        dma_base_s = {src_r, 8'h00} + {8'h00, next_idx_s};
        if (src_r >= ECHO_SRC_MIN) begin
            dma_src_addr_s = clear_bit13(dma_base_s);
        end else begin
            dma_src_addr_s = dma_base_s;
        end
        dma_src_region_s = decode_addr(dma_src_addr_s);
        cpu_region_s     = decode_addr(cpu_addr);
        if (!cpu_mem_enable) begin
            cpu_eff_region_s = UNUSABLE;
        end else if (dma_active_r && (cpu_region_s != HRAM)) begin
            cpu_eff_region_s = UNUSABLE;
        end else begin
            cpu_eff_region_s = cpu_region_s;
        end
        cpu_rd_data_s = read_mux(cpu_region_r, cart_rdata, vram_rdata, wram_rdata,
                                 oam_rdata, io_rdata, hram_rdata_s, src_r);
        dma_rd_data_s = read_mux(dma_region_r, cart_rdata, vram_rdata, wram_rdata,
                                 oam_rdata, io_rdata, hram_rdata_s, src_r);
        sel_any_s = sel_cart_r | sel_vram_r | sel_wram_r | sel_oam_r | sel_io_r;
    end

    // Target bus sequencing: CPU owns t1-t2 when idle; DMA owns t0-t2 when active.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_cart_r    <= 1'b0;
            sel_vram_r    <= 1'b0;
            sel_wram_r    <= 1'b0;
            sel_oam_r     <= 1'b0;
            sel_io_r      <= 1'b0;
            bus_addr_r    <= 16'h0000;
            bus_wdata_r   <= 8'h00;
            bus_write_r   <= 1'b0;
            cpu_data_in_r <= 8'hFF;
            cpu_region_r  <= UNUSABLE;
            dma_region_r  <= UNUSABLE;
            cpu_rd_r      <= 1'b0;
            cpu_wr_r      <= 1'b0;
            hram_sel_r    <= 1'b0;
            hram_we_r     <= 1'b0;
            hram_addr_r   <= 7'd0;
            hram_wdata_r  <= 8'h00;
        end else begin
            case (t_cycle)
                2'd0: begin
                    cpu_region_r <= cpu_eff_region_s;
                    cpu_rd_r     <= cpu_mem_enable && !cpu_mem_write;
                    cpu_wr_r     <= cpu_mem_enable && cpu_mem_write;
                    hram_sel_r   <= (cpu_eff_region_s == HRAM);
                    hram_we_r    <= 1'b0;
                    hram_addr_r  <= cpu_addr[6:0];
                    hram_wdata_r <= cpu_data_out;
                    if (!dma_active_r) begin
                        sel_cart_r <= (cpu_eff_region_s == CART);
                        sel_vram_r <= (cpu_eff_region_s == VRAM);
                        sel_wram_r <= (cpu_eff_region_s == WRAM);
                        sel_oam_r  <= (cpu_eff_region_s == OAM);
                        sel_io_r   <= (cpu_eff_region_s == IO);
                        if (cpu_mem_enable) begin
                            bus_addr_r  <= (cpu_addr >= ECHO_START && cpu_addr <= ECHO_END)
                                           ? clear_bit13(cpu_addr) : cpu_addr;
                            bus_wdata_r <= cpu_data_out;
                        end
                    end
                end
                2'd1: begin
                    hram_we_r <= hram_sel_r && cpu_wr_r;
                    if (dma_active_r) begin
                        sel_cart_r  <= 1'b0;
                        sel_vram_r  <= 1'b0;
                        sel_wram_r  <= 1'b0;
                        sel_oam_r   <= 1'b1;
                        sel_io_r    <= 1'b0;
                        bus_addr_r  <= OAM_START + {8'h00, idx_r};
                        bus_wdata_r <= dma_rd_data_s;
                        bus_write_r <= 1'b1;
                    end else begin
                        bus_write_r <= cpu_wr_r && sel_any_s;
                    end
                end
                2'd2: begin
                    sel_cart_r  <= 1'b0;
                    sel_vram_r  <= 1'b0;
                    sel_wram_r  <= 1'b0;
                    sel_oam_r   <= 1'b0;
                    sel_io_r    <= 1'b0;
                    bus_write_r <= 1'b0;
                    hram_sel_r  <= 1'b0;
                    hram_we_r   <= 1'b0;
                    cpu_rd_r    <= 1'b0;
                    if (cpu_rd_r) begin
                        cpu_data_in_r <= cpu_rd_data_s;
                    end
                end
                2'd3: begin
                    if (next_state_s == DMA_ACTIVE) begin
                        sel_cart_r   <= (dma_src_region_s == CART);
                        sel_vram_r   <= (dma_src_region_s == VRAM);
                        sel_wram_r   <= (dma_src_region_s == WRAM);
                        sel_oam_r    <= (dma_src_region_s == OAM);
                        sel_io_r     <= (dma_src_region_s == IO);
                        bus_addr_r   <= dma_src_addr_s;
                        dma_region_r <= dma_src_region_s;
                        hram_sel_r   <= (dma_src_region_s == HRAM);
                        hram_we_r    <= 1'b0;
                        hram_addr_r  <= dma_src_addr_s[6:0];
                    end
                end
                default: begin
                    bus_write_r <= 1'b0;
                end
            endcase
        end
    end

    assign sel_cart    = sel_cart_r;
    assign sel_vram    = sel_vram_r;
    assign sel_wram    = sel_wram_r;
    assign sel_oam     = sel_oam_r;
    assign sel_io      = sel_io_r;
    assign bus_addr    = bus_addr_r;
    assign bus_wdata   = bus_wdata_r;
    assign bus_write   = bus_write_r;
    assign cpu_data_in = cpu_data_in_r;
    assign dma_active  = dma_active_r;

endmodule

// File: tb/tb_memory_bus.sv
// Directed bench for memory_bus: decode, HRAM, OAM DMA and reset abort.
module tb_memory_bus;

    logic        clk;
    logic        reset_n;
    logic [1:0]  t_cycle;
    logic        cpu_mem_enable, cpu_mem_write;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data_out, cpu_data_in;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_write;
    logic        sel_cart, sel_vram, sel_wram, sel_oam, sel_io;
    logic [7:0]  cart_rdata, vram_rdata, wram_rdata, oam_rdata, io_rdata;
    logic        dma_active;

    int n_checks = 0;
    int n_fail   = 0;

    // monitor state
    int          oam_cnt = 0;
    int          act_cnt = 0;
    int          sel_cnt = 0;
    logic [15:0] oam_log_addr [0:511];
    logic [7:0]  oam_log_data [0:511];

    // per-M-cycle samples, indexed by t-cycle
    logic [4:0]  samp_sel  [0:3];
    logic        samp_wr   [0:3];
    logic        samp_act  [0:3];
    logic [15:0] samp_addr [0:3];
    logic [7:0]  samp_wd   [0:3];
    logic [7:0]  samp_din  [0:3];

    memory_bus #(.DMA_LEN(160)) dut (
        .clk(clk), .reset_n(reset_n), .t_cycle(t_cycle),
        .cpu_mem_enable(cpu_mem_enable), .cpu_mem_write(cpu_mem_write),
        .cpu_addr(cpu_addr), .cpu_data_out(cpu_data_out), .cpu_data_in(cpu_data_in),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_write(bus_write),
        .sel_cart(sel_cart), .sel_vram(sel_vram), .sel_wram(sel_wram),
        .sel_oam(sel_oam), .sel_io(sel_io),
        .cart_rdata(cart_rdata), .vram_rdata(vram_rdata), .wram_rdata(wram_rdata),
        .oam_rdata(oam_rdata), .io_rdata(io_rdata), .dma_active(dma_active)
    );

    // WRAM model: drives data only while selected, byte = low address ^ 79.
    assign wram_rdata = sel_wram ? (bus_addr[7:0] ^ 8'h79) : 8'h00;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Log OAM writes, count DMA-active M-cycles and any-select cycles.
    always @(negedge clk) begin
        if (sel_oam && bus_write) begin
            oam_log_addr[oam_cnt[8:0]] = bus_addr;
            oam_log_data[oam_cnt[8:0]] = bus_wdata;
            oam_cnt++;
        end
        if (dma_active && t_cycle == 2'd0) act_cnt++;
        if (sel_cart | sel_vram | sel_wram | sel_oam | sel_io) sel_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One M-cycle with the given request; outputs sampled at each negedge.
    task automatic mc(input logic en, input logic wr, input logic [15:0] a, input logic [7:0] d);
        for (int t = 0; t < 4; t++) begin
            t_cycle        = 2'(t);
            cpu_mem_enable = en;
            cpu_mem_write  = wr;
            cpu_addr       = a;
            cpu_data_out   = d;
            @(negedge clk);
            samp_sel[t]  = {sel_cart, sel_vram, sel_wram, sel_oam, sel_io};
            samp_wr[t]   = bus_write;
            samp_act[t]  = dma_active;
            samp_addr[t] = bus_addr;
            samp_wd[t]   = bus_wdata;
            samp_din[t]  = cpu_data_in;
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [19:0] sel_pat();
        return {samp_sel[3], samp_sel[2], samp_sel[1], samp_sel[0]};
    endfunction

    function automatic logic [3:0] wr_pat();
        return {samp_wr[3], samp_wr[2], samp_wr[1], samp_wr[0]};
    endfunction

    function automatic logic [3:0] act_pat();
        return {samp_act[3], samp_act[2], samp_act[1], samp_act[0]};
    endfunction

    initial begin
        int s0, a0, o0, o1, bad;
        reset_n = 1'b0; t_cycle = 2'd0;
        cpu_mem_enable = 1'b0; cpu_mem_write = 1'b0; cpu_addr = 16'h0000; cpu_data_out = 8'h00;
        cart_rdata = 8'h3C; vram_rdata = 8'h44; oam_rdata = 8'h66; io_rdata = 8'h9E;
        repeat (3) @(posedge clk);
        #1;
        check("rst_sel", {27'd0, sel_cart, sel_vram, sel_wram, sel_oam, sel_io}, 32'd0);
        check("rst_bus_write", {31'd0, bus_write}, 32'd0);
        check("rst_bus_addr", {16'd0, bus_addr}, 32'h0000);
        check("rst_bus_wdata", {24'd0, bus_wdata}, 32'h00);
        check("rst_cpu_data_in", {24'd0, cpu_data_in}, 32'hFF);
        check("rst_dma_active", {31'd0, dma_active}, 32'd0);
        reset_n = 1'b1;

        mc(1'b1, 1'b0, 16'hC123, 8'h00);
        check("wram_sel", sel_pat(), {5'b0, 5'b00100, 5'b00100, 5'b0});
        check("wram_addr", {16'd0, samp_addr[1]}, 32'hC123);
        check("wram_data", {24'd0, samp_din[3]}, 32'h5A);
        mc(1'b1, 1'b0, 16'hE123, 8'h00);
        check("echo_addr", {16'd0, samp_addr[2]}, 32'hC123);
        check("echo_data", {24'd0, samp_din[3]}, 32'h5A);

        s0 = sel_cnt;
        mc(1'b1, 1'b1, 16'hFF90, 8'h77);
        mc(1'b1, 1'b0, 16'hFF90, 8'h00);
        check("hram_read", {24'd0, samp_din[3]}, 32'h77);
        check("hram_no_sel", 32'(sel_cnt - s0), 32'd0);

        mc(1'b1, 1'b1, 16'h2000, 8'h12);
        check("cart_wr_sel", sel_pat(), {5'b0, 5'b10000, 5'b10000, 5'b0});
        check("cart_wr_strobe", {28'd0, wr_pat()}, 32'b0100);
        check("cart_wr_data", {24'd0, samp_wd[2]}, 32'h12);
        check("cart_wr_addr", {16'd0, samp_addr[2]}, 32'h2000);
        check("cart_wr_din_held", {24'd0, samp_din[3]}, 32'h77);

        mc(1'b1, 1'b0, 16'hFEA5, 8'h00);
        check("unusable_data", {24'd0, samp_din[3]}, 32'hFF);
        check("unusable_sel", sel_pat(), 32'd0);
        mc(1'b1, 1'b0, 16'h0150, 8'h00);
        check("cart_rd", {12'd0, sel_pat()} ^ {24'd0, samp_din[3]},
              {12'd0, 5'b0, 5'b10000, 5'b10000, 5'b0} ^ 32'h3C);
        mc(1'b1, 1'b0, 16'h8000, 8'h00);
        check("vram_rd", {24'd0, samp_din[3]}, 32'h44);
        mc(1'b1, 1'b0, 16'hFF00, 8'h00);
        check("io_rd_sel", sel_pat(), {5'b0, 5'b00001, 5'b00001, 5'b0});
        check("io_rd", {24'd0, samp_din[3]}, 32'h9E);
        mc(1'b1, 1'b0, 16'hFF46, 8'h00);
        check("dmareg_rst", {24'd0, samp_din[3]}, 32'h00);

        // OAM DMA from C100
        a0 = act_cnt; o0 = oam_cnt;
        mc(1'b1, 1'b1, 16'hFF46, 8'hC1);
        check("dma_n_inactive", {28'd0, act_pat()}, 32'd0);
        mc(1'b0, 1'b0, 16'h0000, 8'h00);
        check("dma_setup_inactive", {28'd0, act_pat()}, 32'd0);
        mc(1'b0, 1'b0, 16'h0000, 8'h00);
        check("dma_first_active", {28'd0, act_pat()}, 32'hF);
        check("dma_first_sel", sel_pat(), {5'b0, 5'b00010, 5'b00100, 5'b00100});
        check("dma_first_src", {16'd0, samp_addr[0]}, 32'hC100);
        check("dma_first_dst", {16'd0, samp_addr[2]}, 32'hFE00);
        check("dma_first_byte", {24'd0, samp_wd[2]}, 32'h79);
        check("dma_first_strobe", {28'd0, wr_pat()}, 32'b0100);
        mc(1'b1, 1'b0, 16'h8000, 8'h00);
        check("dma_vram_rd_ff", {24'd0, samp_din[3]}, 32'hFF);
        check("dma_vram_no_sel", {27'd0, samp_sel[1]}, 32'b00100);
        mc(1'b1, 1'b1, 16'hFF46, 8'hC1);
        mc(1'b1, 1'b1, 16'hFF80, 8'hAB);
        mc(1'b1, 1'b0, 16'hFF80, 8'h00);
        check("dma_hram_rd", {24'd0, samp_din[3]}, 32'hAB);
        for (int k = 0; k < 155; k++) mc(1'b0, 1'b0, 16'h0000, 8'h00);
        check("dma_last_active", {28'd0, act_pat()}, 32'hF);
        mc(1'b0, 1'b0, 16'h0000, 8'h00);
        check("dma_done", {28'd0, act_pat()}, 32'd0);
        check("dma_active_mcycles", 32'(act_cnt - a0), 32'd160);
        check("dma_oam_writes", 32'(oam_cnt - o0), 32'd160);
        bad = 0;
        for (int k = 0; k < 160; k++) begin
            if (oam_log_addr[9'(o0 + k)] !== 16'hFE00 + 16'(k)) bad++;
            if (oam_log_data[9'(o0 + k)] !== (8'(k) ^ 8'h79)) bad++;
        end
        check("dma_oam_log", 32'(bad), 32'd0);
        mc(1'b1, 1'b0, 16'hFF46, 8'h00);
        check("dmareg_rd", {24'd0, samp_din[3]}, 32'hC1);

        // DMA aborted by reset at index 50
        o1 = oam_cnt;
        mc(1'b1, 1'b1, 16'hFF46, 8'hC0);
        mc(1'b0, 1'b0, 16'h0000, 8'h00);
        for (int k = 0; k < 50; k++) mc(1'b0, 1'b0, 16'h0000, 8'h00);
        check("abort_oam_before", 32'(oam_cnt - o1), 32'd50);
        t_cycle = 2'd0;
        #2;
        reset_n = 1'b0;
        #1;
        check("abort_dma_active", {31'd0, dma_active}, 32'd0);
        check("abort_sel", {27'd0, sel_cart, sel_vram, sel_wram, sel_oam, sel_io}, 32'd0);
        check("abort_bus_write", {31'd0, bus_write}, 32'd0);
        check("abort_cpu_data_in", {24'd0, cpu_data_in}, 32'hFF);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) mc(1'b0, 1'b0, 16'h0000, 8'h00);
        check("abort_no_more_oam", 32'(oam_cnt - o1), 32'd50);
        check("abort_stays_idle", {28'd0, act_pat()}, 32'd0);
        mc(1'b1, 1'b0, 16'hFF80, 8'h00);
        check("hram_kept", {24'd0, samp_din[3]}, 32'hAB);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/memory_bus.md
# memory_bus

Responder side of the CPU memory interface. It accepts the CPU's per-M-cycle memory requests, decodes the address, and drives a shared target bus with one-hot selects to cartridge, VRAM, WRAM, OAM and I/O. It holds the 127-byte HRAM internally and owns the OAM DMA engine at FF46, which takes over the target bus during transfers.

## Interface
Parameters:
- `DMA_LEN`, 160: bytes per OAM DMA transfer.

Ports:
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `t_cycle` in 2: T-cycle within the M-cycle, 0..3. The M-cycle boundary is the rising edge at which `t_cycle==3`.
- `cpu_mem_enable` in 1: the CPU is accessing memory this M-cycle.
- `cpu_mem_write` in 1: the access is a write. Only meaningful when `cpu_mem_enable` is high.
- `cpu_addr` in 16: request address. Stable from t0 to t3.
- `cpu_data_out` in 8: write data from the CPU. Stable from t0 to t3.
- `cpu_data_in` out 8: read data returned to the CPU.
- `bus_addr` out 16: target address.
- `bus_wdata` out 8: target write data.
- `bus_write` out 1: single-cycle write strobe.
- `sel_cart`, `sel_vram`, `sel_wram`, `sel_oam`, `sel_io` out 1 each: one-hot target selects.
- `cart_rdata`, `vram_rdata`, `wram_rdata`, `oam_rdata`, `io_rdata` in 8 each: target read data. Each target must present valid read data in the second consecutive cycle its select is high.
- `dma_active` out 1: OAM DMA is in progress.

## Operation
- Address decode:
  - 0000-7FFF and A000-BFFF go to cart.
  - 8000-9FFF goes to VRAM.
  - C000-DFFF goes to WRAM.
  - E000-FDFF goes to WRAM, with `bus_addr` bit 13 cleared.
  - FE00-FE9F goes to OAM.
  - FEA0-FEFF is unusable: reads return FF and writes are dropped.
  - FF46 is the internal DMA register.
  - Other FF00-FF7F addresses and FFFF go to I/O.
  - FF80-FFFE goes to internal HRAM.
- Internal accesses (HRAM, FF46, unusable range) assert no select.
- Reading FF46 returns the last value written to it.
- All outputs are registered. At most one select is high in any cycle.
- Reset values:
  - all selects and `bus_write` are 0;
  - `bus_addr` is 0000 and `bus_wdata` is 00;
  - `cpu_data_in` is FF;
  - `dma_active` is 0, the DMA source register is 00 and the DMA index is 0.
  - HRAM contents are not reset.
- Asserting reset mid-access or mid-DMA aborts immediately: all outputs take their reset values and no further strobe is issued.
- OAM DMA:
  - A CPU write to FF46 in M-cycle N, while `dma_active` is low, latches `src` and starts a transfer.
  - M-cycle N+1 is a setup cycle.
  - `dma_active` is high for exactly `DMA_LEN` M-cycles, from N+2 to N+161.
  - In active M-cycle i, the source address is `{src,8'h00}+i`. If `src` is E0-FF, bit 13 is cleared so the read lands in WRAM.
- While DMA is active:
  - CPU access to HRAM proceeds normally.
  - All other CPU reads return FF, and all other CPU writes are dropped.
  - A write to FF46 is ignored and does not restart the transfer.

## Timing
- CPU access in each M-cycle:
  - t0: decode.
  - t1-t2: the decoded select is high, with `bus_addr` and `bus_wdata` valid.
  - Writes: `bus_write` is high during t2 only.
  - Reads: `cpu_data_in` is loaded at the end of t2 with the selected target's data, HRAM data, FF46, or FF. It is valid through t3 and held until the next read capture.
- Writes and idle M-cycles (`cpu_mem_enable` low) never change `cpu_data_in`.
- HRAM follows the same read/write timing as an external target, using an internal select.
- DMA M-cycle:
  - t0-t1: the source select is high and `bus_addr` is the source address. The source byte is latched at the end of t1.
  - t2: `sel_oam` is high, `bus_addr` is FE00+i, `bus_wdata` is the latched byte, and `bus_write` is 1.
  - t3: idle.
- DMA of the final byte: index 159 is written at t2 of M-cycle N+161, and `dma_active` falls at the following M-cycle boundary.
- DMA from FF80-FFFE reads internal HRAM; no external select is asserted.

## Structure
- The shared package holds:
  - `mem_region_e` (Cart, Vram, Wram, Oam, Io, Hram, DmaReg, Unusable);
  - address-boundary constants;
  - `DMA_REG_ADDR` (16'hFF46);
  - the `DMA_LEN` default.
- Sub-module `hram`: 127x8 single-port synchronous RAM with 1-cycle read latency, instantiated once.
- Top-level logic consists of:
  - the decode function;
  - the request/target bus registers;
  - the DMA FSM (Idle, Setup, Active) with an 8-bit index counter.

## Test plan
- Read C123 with `wram_rdata`=5A. Expect `sel_wram` high in t1-t2 and `cpu_data_in`=5A at t3. Read E123 and expect `bus_addr`=C123.
- Write 77 to FF90, then read FF90. Expect 77, with no select ever asserted. A read of FEA5 returns FF.
- Write C1 to FF46. Expect `dma_active` high for exactly 160 M-cycles. Writes to OAM hit FE00..FE9F in order, each carrying the `wram_rdata` returned for C100+i. A subsequent read of FF46 returns C1.
- During DMA:
  - a read of 8000 returns FF with no `sel_vram`;
  - a write to FF46 does not restart the transfer (the count stays at 160);
  - an HRAM read/write at FF80 succeeds.
- Assert `reset_n` low at DMA index 50. Expect `dma_active`, all selects and `bus_write` to drop immediately, `cpu_data_in`=FF, and no further OAM writes.
- Write 12 to 2000. Expect `sel_cart` high in t1-t2, `bus_write` high for exactly one cycle (t2), `bus_wdata`=12, and `cpu_data_in` unchanged.
